// File: rtl/johnson_pkg.sv
// Shared types and helpers for the scheduled Johnson phase generator.
// FSM state encoding plus the round-robin grant selector.
package johnson_pkg;

  localparam int MAX_NREQ = 32;
  localparam int MAX_IDX_W = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // One-hot grant for the first asserted request strictly after ptr, wrapping at nreq.
  function automatic logic [MAX_NREQ-1:0] rr_select(input logic [MAX_NREQ-1:0] req,
                                                    input int nreq,
                                                    input int ptr);
    logic [MAX_NREQ-1:0] sel;
    int idx;
    sel = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= nreq) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (sel == '0 && req[idx[MAX_IDX_W-1:0]]) sel[idx[MAX_IDX_W-1:0]] = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic int onehot_idx(input logic [MAX_NREQ-1:0] oh);
    int r;
    r = 0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (oh[k]) r = k;
    end
    return r;
  endfunction

endpackage

// File: rtl/johnson_seq_sched_ring.sv
// Johnson shift ring with synchronous preset; preset wins over shift.
module johnson_ring
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (shift_en) begin
      count <= {~count[0], count[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/johnson_seq_sched.sv
// Round-robin scheduler that lends one Johnson ring to NREQ requesters
// for a preset pattern plus a bounded number of shifts.
module johnson_seq_sched
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int LEN_W = 5
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_pattern,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  abort,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  count_valid,
  output logic                  done,
  output logic                  done_aborted
);

  localparam int IDX_W = $clog2(NREQ);

  state_t              state;
  logic [NREQ-1:0]     gnt_q;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    gidx;
  logic [LEN_W-1:0]    rem;
  logic [LEN_W-1:0]    len_q;
  logic [WIDTH-1:0]    pat_q;
  logic                aborted_q;

  logic [MAX_NREQ-1:0] req_ext;
  logic [MAX_NREQ-1:0] sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic                ring_load;
  logic                ring_shift;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    sel_oh            = rr_select(req_ext, NREQ, int'(ptr));
    sel_idx           = IDX_W'(onehot_idx(sel_oh));
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      gnt_q     <= '0;
      ptr       <= IDX_W'(NREQ - 1);
      gidx      <= '0;
      rem       <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt_q <= sel_oh[NREQ-1:0];
            gidx  <= sel_idx;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            rem   <= len_q;
            state <= (len_q != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_q     <= '0;
          ptr       <= gidx;
          aborted_q <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Run parameters are captured with the grant so later req-side changes cannot disturb the run.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && |req) begin
      pat_q <= req_pattern[sel_idx*WIDTH +: WIDTH];
      len_q <= req_len[sel_idx*LEN_W +: LEN_W];
    end
  end

  assign ring_load  = (state == ST_LOAD) && !abort;
  assign ring_shift = (state == ST_RUN) && !abort;

  johnson_ring #(
    .WIDTH(WIDTH)
  ) u_ring (
    .clk     (clk),
    .clear   (clear),
    .load    (ring_load),
    .load_val(pat_q),
    .shift_en(ring_shift),
    .count   (count)
  );

  assign gnt          = gnt_q;
  assign busy         = (state != ST_IDLE);
  assign count_valid  = (state == ST_RUN) || (state == ST_DONE);
  assign done         = (state == ST_DONE);
  assign done_aborted = (state == ST_DONE) && aborted_q;

endmodule

// File: tb/tb_johnson_seq_sched.sv
// Self-checking bench for johnson_seq_sched: directed scenarios plus randomized
// runs, each checked cycle by cycle against a run-level reference model.
module tb_johnson_seq_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int LEN_W = 5;

  logic                  clk = 1'b0;
  logic                  clear;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_pattern;
  logic [NREQ*LEN_W-1:0] req_len;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic                  count_valid;
  logic                  done;
  logic                  done_aborted;

  int ncmp = 0;
  int nfail = 0;
  int m_ptr;
  logic [WIDTH-1:0] m_count;

  johnson_seq_sched #(
    .WIDTH(WIDTH),
    .NREQ (NREQ),
    .LEN_W(LEN_W)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .req         (req),
    .req_pattern (req_pattern),
    .req_len     (req_len),
    .abort       (abort),
    .gnt         (gnt),
    .busy        (busy),
    .count       (count),
    .count_valid (count_valid),
    .done        (done),
    .done_aborted(done_aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [NREQ-1:0] e_gnt, input logic e_busy,
                          input logic e_valid, input logic e_done, input logic e_ab,
                          input logic [WIDTH-1:0] e_count);
    chk({tag, ".gnt"},   32'(gnt),          32'(e_gnt));
    chk({tag, ".busy"},  32'(busy),         32'(e_busy));
    chk({tag, ".valid"}, 32'(count_valid),  32'(e_valid));
    chk({tag, ".done"},  32'(done),         32'(e_done));
    chk({tag, ".abrt"},  32'(done_aborted), 32'(e_ab));
    chk({tag, ".count"}, 32'(count),        32'(e_count));
  endtask

  function automatic int winner(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] jshift(input logic [WIDTH-1:0] c);
    return {~c[0], c[WIDTH-1:1]};
  endfunction

  task automatic set_slot(input int i, input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] len);
    req_pattern[i*WIDTH +: WIDTH] = pat;
    req_len[i*LEN_W +: LEN_W]     = len;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
  // abort_at: -1 none, 0 during LOAD, j during the j-th RUN cycle.
  task automatic run(input string tag, input logic [NREQ-1:0] mask, input int abort_at,
                     input bit chg, input logic [NREQ-1:0] chg_mask);
    int g;
    int len;
    bit ab;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] cur;
    logic [NREQ-1:0] eg;
    req = mask;
    g   = winner(mask, m_ptr);
    pat = req_pattern[g*WIDTH +: WIDTH];
    len = int'(req_len[g*LEN_W +: LEN_W]);
    eg  = NREQ'(1) << g;
    @(negedge clk);
    chk_outs({tag, ".load"}, eg, 1'b1, 1'b0, 1'b0, 1'b0, m_count);
    ab  = 1'b0;
    cur = m_count;
    if (abort_at == 0) begin
      abort = 1'b1;
      ab    = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    if (!ab) begin
      cur = pat;
      for (int j = 1; j <= len; j++) begin
        chk_outs({tag, ".run"}, eg, 1'b1, 1'b1, 1'b0, 1'b0, cur);
        if (chg && j == 1) req = chg_mask;
        if (abort_at == j) begin
          abort = 1'b1;
          ab    = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        if (ab) break;
        cur = jshift(cur);
      end
    end
    chk_outs({tag, ".done"}, eg, 1'b1, 1'b1, 1'b1, ab, cur);
    m_count = cur;
    m_ptr   = g;
    @(negedge clk);
    chk_outs({tag, ".idle"}, '0, 1'b0, 1'b0, 1'b0, 1'b0, cur);
  endtask

  initial begin
    int g;
    int len;
    int ab_at;
    logic [NREQ-1:0] mask;

    clear       = 1'b0;
    req         = '0;
    abort       = 1'b0;
    req_pattern = '0;
    req_len     = '0;
    m_ptr       = NREQ - 1;
    m_count     = '0;

    @(negedge clk);
    chk_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    clear = 1'b1;
    @(negedge clk);
    chk_outs("post_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Single run from requester 1: 0000 shifted 8 times walks back to 0000.
    set_slot(1, 4'b0000, 5'd8);
    run("single", 4'b0010, -1, 1'b0, '0);
    chk("single.end_count", 32'(count), 32'h0);
    req = '0;

    set_slot(2, 4'b1010, 5'd0);
    run("len0", 4'b0100, -1, 1'b0, '0);
    req = '0;

    // Reset in the middle of a run.
    set_slot(2, 4'b0011, 5'd10);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #2 clear = 1'b0;
    #1;
    chk_outs("midreset", '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    req = '0;
    @(negedge clk);
    clear   = 1'b1;
    m_ptr   = NREQ - 1;
    m_count = '0;

    // Round robin with every requester asserted.
    for (int i = 0; i < NREQ; i++) set_slot(i, 4'($urandom_range(0, 15)), 5'd1);
    for (int r = 0; r < 5; r++) begin
      g = winner(4'b1111, m_ptr);
      chk("rr.order", 32'(g), 32'(r % NREQ));
      run("rr", 4'b1111, -1, 1'b0, '0);
    end
    req = '0;

    // Abort during the third RUN cycle of a long run.
    set_slot(3, 4'b0110, 5'd20);
    run("abort", 4'b1000, 3, 1'b0, '0);
    req = '0;

    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_outs("abort_idle", '0, 1'b0, 1'b0, 1'b0, 1'b0, m_count);
    end
    abort = 1'b0;

    // Requester 0 drops and requester 2 rises mid-run; the run still completes.
    set_slot(0, 4'b1001, 5'd6);
    set_slot(2, 4'b0100, 5'd3);
    run("late0", 4'b0001, -1, 1'b1, 4'b0100);
    run("late2", 4'b0100, -1, 1'b0, '0);
    req = '0;
    @(negedge clk);

    // Randomized runs, occasionally aborted, with optional idle gaps.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NREQ; i++)
        set_slot(i, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 12)));
      mask  = 4'($urandom_range(1, 15));
      g     = winner(mask, m_ptr);
      len   = int'(req_len[g*LEN_W +: LEN_W]);
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run("rand", mask, ab_at, 1'b0, '0);
      if ($urandom_range(0, 1) == 1) begin
        req = '0;
        @(negedge clk);
        chk_outs("rand.gap", '0, 1'b0, 1'b0, 1'b0, 1'b0, m_count);
      end
    end
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
